// File: rtl/sitcp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sitcp_pkg
// Brief   : Shared constants and serializer state type for the SiTCP TX path.
// Revision: 1.0
// ============================================================================
package sitcp_pkg;

  localparam int TCP_BYTE_W     = 8;
  localparam int TCP_WORD_BYTES = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/tcp_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tcp_tx_fifo
// Brief   : Single-clock word FIFO with flush, full/empty and fill level.
// Revision: 1.0
// ============================================================================
module tcp_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 36
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_pop_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  // DEPTH is a power of two, so the full level is just the top level bit.
  localparam logic [AW:0] c_FULL_LEVEL = {1'b1, {AW{1'b0}}};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full     = (r_level == c_FULL_LEVEL);
  assign o_empty    = (r_level == '0);
  assign o_level    = r_level;
  assign o_pop_data = r_mem[r_rd_ptr];
  assign w_push     = i_push & ~o_full;
  assign w_pop      = i_pop & ~o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= r_level + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule
`default_nettype wire

// File: rtl/axis_tcp_tx.sv
`default_nettype none
// ============================================================================
// Module  : axis_tcp_tx
// Brief   : AXI-Stream 32-bit words to SiTCP TCP TX byte port serializer.
// Revision: 1.0
// ============================================================================
module axis_tcp_tx
  import sitcp_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int MSB_FIRST  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   s_axis_tdata,
  input  logic [3:0]                    s_axis_tkeep,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          tcp_open_ack,
  input  logic                          tcp_tx_full,
  output logic                          tcp_tx_wr,
  output logic [7:0]                    tcp_txd,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [31:0]                   byte_count,
  output logic [15:0]                   drop_count
);

  localparam int c_WORD_W  = TCP_BYTE_W * TCP_WORD_BYTES;
  localparam int c_ENTRY_W = c_WORD_W + TCP_WORD_BYTES;
  localparam logic [1:0] c_LAST_LANE = 2'(TCP_WORD_BYTES - 1);

  tx_state_t                   r_state;
  tx_state_t                   w_state_next;
  logic                        r_full_q;
  logic                        r_alive;
  logic [c_WORD_W-1:0]         r_shift_data;
  logic [TCP_WORD_BYTES-1:0]   r_shift_keep;
  logic [1:0]                  r_lane;
  logic [1:0]                  w_lane_sel;
  logic                        r_tx_wr;
  logic [TCP_BYTE_W-1:0]       r_txd;
  logic [31:0]                 r_byte_count;
  logic [15:0]                 r_drop_count;

  logic [c_ENTRY_W-1:0]        w_fifo_dout;
  logic                        w_fifo_full;
  logic                        w_fifo_empty;
  logic                        w_handshake;
  logic                        w_push;
  logic                        w_accept_drop;
  logic                        w_pop;
  logic                        w_slot;
  logic                        w_partial_drop;
  logic                        w_wr_next;
  logic [TCP_BYTE_W-1:0]       w_byte;
  logic [16:0]                 w_drop_inc;
  logic [16:0]                 w_drop_sum;

  // r_alive keeps tready low while in reset and for the first edge after.
  assign s_axis_tready = r_alive & (~tcp_open_ack | ~w_fifo_full);
  assign w_handshake   = s_axis_tvalid & s_axis_tready;
  assign w_push        = w_handshake & tcp_open_ack;
  assign w_accept_drop = w_handshake & ~tcp_open_ack;

  tcp_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (c_ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (~tcp_open_ack),
    .i_push      (w_push),
    .i_push_data ({s_axis_tkeep, s_axis_tdata}),
    .i_pop       (w_pop),
    .o_pop_data  (w_fifo_dout),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_level     (fifo_level)
  );

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_lane_sel = c_LAST_LANE - r_lane;
    end else begin : g_lsb_first
      assign w_lane_sel = r_lane;
    end
  endgenerate

  assign w_byte    = r_shift_data[w_lane_sel*TCP_BYTE_W +: TCP_BYTE_W];
  assign w_wr_next = w_slot & r_shift_keep[w_lane_sel];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next   = r_state;
    w_pop          = 1'b0;
    w_slot         = 1'b0;
    w_partial_drop = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (tcp_open_ack && !w_fifo_empty) begin
          w_pop        = 1'b1;
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!tcp_open_ack) begin
          w_partial_drop = 1'b1;
          w_state_next   = ST_IDLE;
        end else if (!r_full_q) begin
          w_slot = 1'b1;
          // Chain straight into the next word so there is no gap between words.
          if (r_lane == c_LAST_LANE) begin
            if (!w_fifo_empty) w_pop = 1'b1;
            else               w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // A close flushes everything queued, so the whole level counts as dropped.
  always_comb begin
    w_drop_inc = '0;
    if (!tcp_open_ack) w_drop_inc = 17'(fifo_level);
    w_drop_inc = w_drop_inc + 17'(w_partial_drop) + 17'(w_accept_drop);
    w_drop_sum = {1'b0, r_drop_count} + w_drop_inc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full_q     <= 1'b0;
      r_alive      <= 1'b0;
      r_shift_data <= '0;
      r_shift_keep <= '0;
      r_lane       <= '0;
      r_tx_wr      <= 1'b0;
      r_txd        <= '0;
      r_byte_count <= '0;
      r_drop_count <= '0;
    end else begin
      r_full_q <= tcp_tx_full;
      r_alive  <= 1'b1;
      r_tx_wr  <= w_wr_next;
      if (w_wr_next) begin
        r_txd        <= w_byte;
        r_byte_count <= r_byte_count + 32'd1;
      end
      if (w_pop) begin
        r_shift_data <= w_fifo_dout[c_WORD_W-1:0];
        r_shift_keep <= w_fifo_dout[c_ENTRY_W-1:c_WORD_W];
        r_lane       <= '0;
      end else if (w_slot) begin
        r_lane <= r_lane + 2'd1;
      end
      if (w_drop_sum[16]) r_drop_count <= 16'hFFFF;
      else                r_drop_count <= w_drop_sum[15:0];
    end
  end

  assign tcp_tx_wr  = r_tx_wr;
  assign tcp_txd    = r_txd;
  assign byte_count = r_byte_count;
  assign drop_count = r_drop_count;

endmodule
`default_nettype wire
